serv_irq_arb: RTL

//  External-interrupt arbiter/sequencer in front of the CSR unit's meip input.

---
 rtl/serv_irq_pkg.sv | 13 +
 rtl/serv_irq_arb_prio.sv | 26 ++
 rtl/serv_irq_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serv_irq_pkg.sv
// Shared definitions for the external-interrupt arbiter: FSM state encoding
// and the supported source-count limit.
package serv_irq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } irq_state_e;

    localparam int unsigned MAX_N_SRC = 16;

endpackage

// File: rtl/serv_irq_arb_prio.sv
// Fixed-priority encoder: index 0 has the highest priority.
// valid is high when any request bit is set; id is the lowest set index.
module serv_irq_arb_prio
    import serv_irq_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] id
);

    // Scan upward; the first set bit found wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                id    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/serv_irq_arb.sv
// External-interrupt arbiter/sequencer feeding the CSR unit's meip input.
// Picks one enabled pending source by fixed priority, holds o_meip until
// trap entry, then tracks the handler until mret so only one source is in
// service at a time.
// Optional feature: define SERV_IRQ_EDGE_EN to add per-source edge mode
// (port i_cfg_edge); without it every source is level-sensitive.
module serv_irq_arb
    import serv_irq_pkg::*;
#(
    parameter int unsigned N_SRC          = 4,
    parameter string       RESET_STRATEGY = "MINI"
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_SRC-1:0]          i_src,
    input  logic                      i_cfg_we,
    input  logic [N_SRC-1:0]          i_cfg_mask,
`ifdef SERV_IRQ_EDGE_EN
    input  logic [N_SRC-1:0]          i_cfg_edge,
`endif
    output logic [N_SRC-1:0]          o_mask,
    output logic [N_SRC-1:0]          o_pending,
    output logic                      o_meip,
    input  logic                      i_ext_taken,
    input  logic                      i_mret_done,
    output logic [$clog2(N_SRC)-1:0]  o_claim_id,
    output logic                      o_active
);

    localparam int unsigned IDW     = $clog2(N_SRC);
    localparam bit          RST_ALL = (RESET_STRATEGY != "NONE");

    irq_state_e       state, state_next;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] eligible;
    logic [IDW-1:0]   claim_q;
    logic             win_valid;
    logic [IDW-1:0]   win_id;

    // Mask register; a write lands on the next edge, so arbitration in the
    // same cycle still sees the old mask.
    always_ff @(posedge i_clk) begin
        if (i_rst && RST_ALL) begin
            mask_q <= '0;
        end else if (i_cfg_we) begin
            mask_q <= i_cfg_mask;
        end
    end

`ifdef SERV_IRQ_EDGE_EN
    logic [N_SRC-1:0] edge_q;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] latch_q;
    logic [N_SRC-1:0] clr;

    // Clear the claimed source's latched edge as it enters service.
    always_comb begin
        clr = '0;
        if (state == PEND && i_ext_taken) begin
            clr = N_SRC'(1) << claim_q;
        end
    end

    // Edge-mode latch: a rising edge sets, entry to service clears, and a
    // set in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst && RST_ALL) begin
            edge_q  <= '0;
            src_q   <= '0;
            latch_q <= '0;
        end else begin
            if (i_cfg_we) begin
                edge_q <= i_cfg_edge;
            end
            src_q   <= i_src;
            latch_q <= (latch_q & ~clr) | (i_src & ~src_q & edge_q);
        end
    end

    assign pending = (edge_q & latch_q) | (~edge_q & i_src);
`else
    assign pending = i_src;
`endif

    assign eligible = pending & mask_q;

    serv_irq_arb_prio #(
        .N   (N_SRC),
        .IDW (IDW)
    ) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; stray completion pulses in the wrong state are ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (win_valid)   state_next = PEND;
            PEND:    if (i_ext_taken) state_next = ACTIVE;
            ACTIVE:  if (i_mret_done) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Claimed id is captured only on the IDLE->PEND decision and then frozen.
    always_ff @(posedge i_clk) begin
        if (i_rst && RST_ALL) begin
            claim_q <= '0;
        end else if (state == IDLE && win_valid) begin
            claim_q <= win_id;
        end
    end

    // Output decode from the current state.
    always_comb begin
        o_meip   = (state == PEND);
        o_active = (state == ACTIVE);
    end

    assign o_mask     = mask_q;
    assign o_pending  = eligible;
    assign o_claim_id = claim_q;

endmodule
